multi_signal_generator: RTL and testbench

Parametrised multi-channel successor to the single-channel signal generator in the analog user-project wrapper. A Wishbone-classic slave exposes one register bank per channel. Each channel runs an independent prescaler and phase accumulator that produce a sawtooth, triangle, square or PWM sample plus a 1-bit waveform. Outputs drive DAC/io pins, and a per-channel sticky wrap flag feeds a shared interrupt.

---
 rtl/multi_signal_generator.sv | 192 +++++++++++++++++++
 tb/tb_multi_signal_generator.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_signal_generator.sv
// Multi-channel Wishbone signal generator: per-channel prescaler and phase
// accumulator producing square, sawtooth, triangle or PWM samples.
module multi_signal_generator #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic [31:0]              wbs_dat_o,
    output logic                     wbs_ack_o,
    output logic [NUM_CH*DATA_W-1:0] sample_o,
    output logic [NUM_CH-1:0]        wave_o,
    output logic                     irq_o
);

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_PWM    = 2'd3
    } mode_t;

    localparam logic [DATA_W-1:0] PH_MAX   = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] PH_ONE   = DATA_W'(1);
    localparam logic [31:0]       ID_VALUE = {8'h5A, 8'(NUM_CH), 8'(DATA_W), 8'h01};

    logic [NUM_CH-1:0]  en_q, irq_en_q, dir_q, wrap_q;
    logic [NUM_CH-1:0]  dir_nx, wrap_set, ch_wr;
    mode_t              mode_q   [NUM_CH];
    logic [PRESC_W-1:0] div_q    [NUM_CH];
    logic [PRESC_W-1:0] presc_q  [NUM_CH];
    logic [PRESC_W-1:0] presc_nx [NUM_CH];
    logic [DATA_W-1:0]  duty_q   [NUM_CH];
    logic [DATA_W-1:0]  phase_q  [NUM_CH];
    logic [DATA_W-1:0]  phase_nx [NUM_CH];

    logic        wb_req, wb_wr, ch_space, sync_wr;
    logic [2:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic [31:0] rdata;
    logic        unused_bits;

    assign wb_req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wb_wr       = wb_req & wbs_we_i;
    assign ch_space    = ~wbs_adr_i[7];
    assign ch_sel      = wbs_adr_i[6:4];
    assign reg_sel     = wbs_adr_i[3:2];
    assign sync_wr     = wb_wr & wbs_adr_i[7] & (wbs_adr_i[6:2] == 5'd0);
    assign unused_bits = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = sel[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        return res;
    endfunction

    always_comb begin
        rdata = '0;
        ch_wr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_wr[c] = wb_wr & ch_space & (ch_sel == 3'(c));
            if (ch_space && ch_sel == 3'(c)) begin
                case (reg_sel)
                    2'd0: rdata = {28'd0, irq_en_q[c], mode_q[c], en_q[c]};
                    2'd1: rdata = 32'(div_q[c]);
                    2'd2: rdata = 32'(duty_q[c]);
                    default: begin
                        rdata     = 32'(phase_q[c]);
                        rdata[16] = wrap_q[c];
                    end
                endcase
            end
        end
        if (!ch_space && wbs_adr_i[6:2] == 5'd1)
            rdata = ID_VALUE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= (wb_req && !wbs_we_i) ? rdata : '0;
        end
    end

    // Triangle reverses at the top without repeating it; the return to zero is its wrap.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            presc_nx[c] = presc_q[c] + PRESC_W'(1);
            phase_nx[c] = phase_q[c];
            dir_nx[c]   = dir_q[c];
            wrap_set[c] = 1'b0;
            if (!en_q[c] || (sync_wr && wbs_dat_i[c])) begin
                presc_nx[c] = '0;
                phase_nx[c] = '0;
                dir_nx[c]   = 1'b0;
            end else if (presc_q[c] >= div_q[c]) begin
                presc_nx[c] = '0;
                if (mode_q[c] == MODE_TRI) begin
                    if (!dir_q[c]) begin
                        if (phase_q[c] == PH_MAX) begin
                            phase_nx[c] = PH_MAX - PH_ONE;
                            dir_nx[c]   = 1'b1;
                        end else begin
                            phase_nx[c] = phase_q[c] + PH_ONE;
                        end
                    end else begin
                        phase_nx[c] = phase_q[c] - PH_ONE;
                        if (phase_q[c] == PH_ONE) begin
                            dir_nx[c]   = 1'b0;
                            wrap_set[c] = 1'b1;
                        end
                    end
                end else begin
                    phase_nx[c] = phase_q[c] + PH_ONE;
                    dir_nx[c]   = 1'b0;
                    wrap_set[c] = (phase_q[c] == PH_MAX);
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            en_q     <= '0;
            irq_en_q <= '0;
            dir_q    <= '0;
            wrap_q   <= '0;
            sample_o <= '0;
            wave_o   <= '0;
            irq_o    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                mode_q[c]  <= MODE_SQUARE;
                div_q[c]   <= '0;
                duty_q[c]  <= '0;
                presc_q[c] <= '0;
                phase_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                presc_q[c] <= presc_nx[c];
                phase_q[c] <= phase_nx[c];
                dir_q[c]   <= dir_nx[c];
                wrap_q[c]  <= wrap_set[c] |
                              (wrap_q[c] & ~(ch_wr[c] && reg_sel == 2'd3 && wbs_dat_i[16]));
                if (ch_wr[c] && reg_sel == 2'd0 && wbs_sel_i[0]) begin
                    en_q[c]     <= wbs_dat_i[0];
                    mode_q[c]   <= mode_t'(wbs_dat_i[2:1]);
                    irq_en_q[c] <= wbs_dat_i[3];
                end
                if (ch_wr[c] && reg_sel == 2'd1)
                    div_q[c] <= PRESC_W'(byte_merge(32'(div_q[c]), wbs_dat_i, wbs_sel_i));
                if (ch_wr[c] && reg_sel == 2'd2)
                    duty_q[c] <= DATA_W'(byte_merge(32'(duty_q[c]), wbs_dat_i, wbs_sel_i));

                if (!en_q[c]) begin
                    sample_o[c*DATA_W +: DATA_W] <= '0;
                    wave_o[c]                    <= 1'b0;
                end else begin
                    case (mode_q[c])
                        MODE_SQUARE: begin
                            sample_o[c*DATA_W +: DATA_W] <= {DATA_W{phase_q[c][DATA_W-1]}};
                            wave_o[c]                    <= phase_q[c][DATA_W-1];
                        end
                        MODE_SAW, MODE_TRI: begin
                            sample_o[c*DATA_W +: DATA_W] <= phase_q[c];
                            wave_o[c]                    <= phase_q[c][DATA_W-1];
                        end
                        default: begin
                            sample_o[c*DATA_W +: DATA_W] <= {DATA_W{phase_q[c] < duty_q[c]}};
                            wave_o[c]                    <= (phase_q[c] < duty_q[c]);
                        end
                    endcase
                end
            end
            irq_o <= |(wrap_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_multi_signal_generator.sv
// Self-checking bench for multi_signal_generator: register-access table,
// directed waveform/IRQ/SYNC sequences and randomized channels vs. an arithmetic model.
module tb_multi_signal_generator;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 8;
    localparam int PRESC_W = 16;

    logic                     wb_clk_i  = 1'b0;
    logic                     wb_rst_ni = 1'b0;
    logic                     wbs_cyc_i = 1'b0;
    logic                     wbs_stb_i = 1'b0;
    logic                     wbs_we_i  = 1'b0;
    logic [3:0]               wbs_sel_i = 4'h0;
    logic [31:0]              wbs_adr_i = 32'h0;
    logic [31:0]              wbs_dat_i = 32'h0;
    logic [31:0]              wbs_dat_o;
    logic                     wbs_ack_o;
    logic [NUM_CH*DATA_W-1:0] sample_o;
    logic [NUM_CH-1:0]        wave_o;
    logic                     irq_o;

    int          check_count = 0;
    int          error_count = 0;
    int unsigned cycle       = 0;
    int unsigned last_commit = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp_read;
    } vec_t;

    vec_t vecs [22];

    multi_signal_generator #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .sample_o  (sample_o),
        .wave_o    (wave_o),
        .irq_o     (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cycle <= cycle + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                           input logic [3:0] bsel, output logic [31:0] rdata, output int latency);
        if (wbs_ack_o) tick(1);
        wbs_adr_i = addr;
        wbs_we_i  = write;
        wbs_dat_i = wdata;
        wbs_sel_i = bsel;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        latency   = 0;
        do begin
            tick(1);
            latency++;
        end while (!wbs_ack_o && latency < 8);
        rdata       = wbs_dat_o;
        last_commit = cycle;
        wbs_cyc_i   = 1'b0;
        wbs_stb_i   = 1'b0;
        wbs_we_i    = 1'b0;
        if (!wbs_ack_o) check_output("ackTimeout", 32'(latency), 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        int          lat;
        wb_xfer(addr, 1'b1, wdata, 4'hF, rd, lat);
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] rdata);
        int lat;
        wb_xfer(addr, 1'b0, 32'h0, 4'hF, rdata, lat);
    endtask

    task automatic apply_stimulus(input int idx);
        logic [31:0] rd;
        int          lat;
        wb_xfer(vecs[idx].addr, vecs[idx].we, vecs[idx].wdata, vecs[idx].sel, rd, lat);
        check_output($sformatf("ackLatency[%0d]", idx), 32'(lat), 32'd1);
        if (!vecs[idx].we)
            check_output($sformatf("regRead[%0d]", idx), rd, vecs[idx].exp_read);
    endtask

    // Reference model: phase as a pure function of elapsed ticks.
    function automatic int model_phase(input int mode, input int ticks);
        int t;
        if (mode == 2) begin
            t = ticks % 510;
            return (t <= 255) ? t : 510 - t;
        end
        return ticks % 256;
    endfunction

    function automatic int model_sample(input int mode, input int phase, input int duty);
        case (mode)
            0:       return (phase >= 128) ? 255 : 0;
            3:       return (phase < duty) ? 255 : 0;
            default: return phase;
        endcase
    endfunction

    function automatic int model_wave(input int mode, input int phase, input int duty);
        if (mode == 3) return (phase < duty) ? 1 : 0;
        return (phase >= 128) ? 1 : 0;
    endfunction

    function automatic int model_wrapped(input int mode, input int ticks);
        if (mode == 2) return (ticks >= 510) ? 1 : 0;
        return (ticks >= 256) ? 1 : 0;
    endfunction

    function automatic logic [7:0] ch_sample(input int c);
        return sample_o[c*DATA_W +: DATA_W];
    endfunction

    initial begin
        logic [31:0] rd;
        int unsigned n0, ns, target;
        int          tri_err, cnt255, cnt0, hi, irq_cycle;
        int          c, mode, d, duty, wait_n, m, ph;

        vecs[0]  = '{32'h04, 1'b0, 32'h0,        4'hF, 32'h0};
        vecs[1]  = '{32'h08, 1'b0, 32'h0,        4'hF, 32'h0};
        vecs[2]  = '{32'h84, 1'b0, 32'h0,        4'hF, 32'h5A040801};
        vecs[3]  = '{32'h80, 1'b0, 32'h0,        4'hF, 32'h0};
        vecs[4]  = '{32'hFC, 1'b0, 32'h0,        4'hF, 32'h0};
        vecs[5]  = '{32'h14, 1'b1, 32'h1234,     4'hF, 32'h0};
        vecs[6]  = '{32'h14, 1'b0, 32'h0,        4'hF, 32'h1234};
        vecs[7]  = '{32'h14, 1'b1, 32'hABCD,     4'h1, 32'h0};
        vecs[8]  = '{32'h14, 1'b0, 32'h0,        4'hF, 32'h12CD};
        vecs[9]  = '{32'h14, 1'b1, 32'hFFFFFFFF, 4'hC, 32'h0};
        vecs[10] = '{32'h14, 1'b0, 32'h0,        4'hF, 32'h12CD};
        vecs[11] = '{32'h18, 1'b1, 32'h1FF,      4'hF, 32'h0};
        vecs[12] = '{32'h18, 1'b0, 32'h0,        4'hF, 32'hFF};
        vecs[13] = '{32'h30, 1'b1, 32'hFE,       4'hF, 32'h0};
        vecs[14] = '{32'h30, 1'b0, 32'h0,        4'hF, 32'hE};
        vecs[15] = '{32'h30, 1'b1, 32'hFF,       4'h0, 32'h0};
        vecs[16] = '{32'h30, 1'b0, 32'h0,        4'hF, 32'hE};
        vecs[17] = '{32'h30, 1'b1, 32'h0,        4'hF, 32'h0};
        vecs[18] = '{32'h50, 1'b1, 32'hF,        4'hF, 32'h0};
        vecs[19] = '{32'h50, 1'b0, 32'h0,        4'hF, 32'h0};
        vecs[20] = '{32'h00, 1'b0, 32'h0,        4'hF, 32'h0};
        vecs[21] = '{32'h3C, 1'b0, 32'h0,        4'hF, 32'h0};

        $display("[TB] reset");
        tick(2);
        wb_rst_ni = 1'b1;
        check_output("rstSample", 32'(sample_o), 32'h0);
        check_output("rstWave",   32'(wave_o),   32'h0);
        check_output("rstIrq",    32'(irq_o),    32'h0);
        check_output("rstAck",    32'(wbs_ack_o), 32'h0);
        check_output("rstDat",    wbs_dat_o,     32'h0);

        // Write presented while reset is asserted must be dropped.
        wbs_adr_i = 32'h08; wbs_dat_i = 32'h55; wbs_sel_i = 4'hF;
        wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wb_rst_ni = 1'b0;
        tick(1);
        check_output("rstDropsAck", 32'(wbs_ack_o), 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wb_rst_ni = 1'b1;
        tick(1);

        $display("[TB] register table");
        for (int i = 0; i < 22; i++) apply_stimulus(i);

        $display("[TB] sawtooth ch0");
        wb_write(32'h04, 32'd3);
        wb_write(32'h00, 32'h3);
        n0 = last_commit;
        while (cycle < n0 + 4) tick(1);
        check_output("sawHold", 32'(ch_sample(0)), 32'h0);
        tick(1);
        check_output("sawStep", 32'(ch_sample(0)), 32'h1);
        wb_read(32'h0C, rd);
        check_output("sawMidWrap",  32'(rd[16]), 32'h0);
        check_output("sawMidPhase", 32'(rd[7:0]), 32'(((last_commit - 1 - n0) / 4) % 256));
        while (cycle < n0 + 1024) tick(1);
        check_output("sawTop", 32'(ch_sample(0)), 32'hFF);
        tick(1);
        check_output("sawWrapTo0", 32'(ch_sample(0)), 32'h0);
        wb_read(32'h0C, rd);
        check_output("sawWrapFlag", 32'(rd[16]), 32'h1);

        $display("[TB] triangle ch1");
        wb_write(32'h14, 32'd0);
        wb_write(32'h1C, 32'h10000);
        wb_write(32'h10, 32'h5);
        n0 = last_commit;
        tri_err = 0; cnt255 = 0; cnt0 = 0;
        for (int k = 0; k < 520; k++) begin
            while (cycle < n0 + 1 + k) tick(1);
            if (int'(ch_sample(1)) != model_phase(2, k)) tri_err++;
            if (k < 510) begin
                if (ch_sample(1) == 8'hFF) cnt255++;
                if (ch_sample(1) == 8'h00) cnt0++;
            end
        end
        check_output("triangleSeq",  32'(tri_err), 32'h0);
        check_output("triangleTop",  32'(cnt255),  32'h1);
        check_output("triangleZero", 32'(cnt0),    32'h1);
        wb_read(32'h1C, rd);
        check_output("triangleWrap", 32'(rd[16]), 32'h1);

        $display("[TB] pwm ch2");
        wb_write(32'h24, 32'd0);
        wb_write(32'h28, 32'h40);
        wb_write(32'h20, 32'h7);
        tick(2);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            tick(1);
            if (wave_o[2]) hi++;
        end
        check_output("pwmDuty40", 32'(hi), 32'd64);
        wb_write(32'h28, 32'h0);
        tick(2);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            tick(1);
            if (wave_o[2]) hi++;
        end
        check_output("pwmDuty0", 32'(hi), 32'd0);

        $display("[TB] irq ch3");
        wb_write(32'h34, 32'd0);
        wb_write(32'h30, 32'hB);
        n0 = last_commit;
        irq_cycle = -1;
        for (int k = 0; k < 400; k++) begin
            if (irq_o) begin
                irq_cycle = int'(cycle - n0);
                break;
            end
            tick(1);
        end
        check_output("irqRise", 32'(irq_cycle), 32'd257);
        wb_write(32'h3C, 32'h10000);
        check_output("irqHeldOnClear", 32'(irq_o), 32'h1);
        tick(1);
        check_output("irqCleared", 32'(irq_o), 32'h0);
        target = n0 + 512;
        while (cycle < target - 1) tick(1);
        wb_write(32'h3C, 32'h10000);
        wb_read(32'h3C, rd);
        check_output("wrapSetWins", 32'(rd[16]), 32'h1);
        wb_write(32'h30, 32'h0);
        wb_write(32'h3C, 32'h10000);
        tick(2);
        check_output("irqOff", 32'(irq_o), 32'h0);

        $display("[TB] sync");
        wb_write(32'h00, 32'h0);
        wb_write(32'h04, 32'd0);
        wb_write(32'h00, 32'h3);
        tick(37);
        wb_write(32'h10, 32'h0);
        wb_write(32'h14, 32'd1);
        wb_write(32'h10, 32'h3);
        tick(20);
        wb_write(32'h80, 32'h3);
        ns = last_commit;
        tick(1);
        check_output("syncCh0Zero", 32'(ch_sample(0)), 32'h0);
        check_output("syncCh1Zero", 32'(ch_sample(1)), 32'h0);
        while (cycle < ns + 11) tick(1);
        check_output("syncCh0Run", 32'(ch_sample(0)), 32'd10);
        check_output("syncCh1Run", 32'(ch_sample(1)), 32'd5);

        $display("[TB] random channels");
        for (int it = 0; it < 10; it++) begin
            c      = int'($urandom_range(0, 3));
            mode   = int'($urandom_range(0, 3));
            d      = int'($urandom_range(0, 3));
            duty   = int'($urandom_range(0, 255));
            wait_n = int'($urandom_range(2, 700));
            wb_write(32'(c * 16),      32'h0);
            wb_write(32'(c * 16 + 12), 32'h10000);
            wb_write(32'(c * 16 + 4),  32'(d));
            wb_write(32'(c * 16 + 8),  32'(duty));
            wb_write(32'(c * 16),      32'((mode << 1) | 1));
            n0 = last_commit;
            tick(wait_n);
            m  = int'(cycle - 1 - n0) / (d + 1);
            ph = model_phase(mode, m);
            check_output($sformatf("rndSample[%0d]", it), 32'(ch_sample(c)), 32'(model_sample(mode, ph, duty)));
            check_output($sformatf("rndWave[%0d]", it),   32'(wave_o[c]),    32'(model_wave(mode, ph, duty)));
            wb_read(32'(c * 16 + 12), rd);
            m = int'(last_commit - 1 - n0) / (d + 1);
            check_output($sformatf("rndPhase[%0d]", it), 32'(rd[7:0]), 32'(model_phase(mode, m)));
            check_output($sformatf("rndWrap[%0d]", it),  32'(rd[16]),  32'(model_wrapped(mode, m)));
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
